// File: rtl/snn_wmem_pkg.sv
// Shared types and the weight-update arithmetic helper for the weight memory arbiter.
// The helper serves both the saturating (WMEM_SATURATE_EN) and the wrapping builds.
package snn_wmem_pkg;

  typedef enum logic [1:0] {IDLE, RD, WB} rmw_state_e;
  typedef enum logic [1:0] {NONE, INF, LRN} rd_owner_e;

  // Clamps old+delta to the signed ww-bit range when sat is set; otherwise returns
  // the raw sum and the caller's truncation to ww bits gives two's-complement wrap.
  function automatic int sat_add(input int old, input int delta, input int ww, input bit sat);
    int s;
    int hi;
    int lo;
    s  = old + delta;
    hi = (1 << (ww - 1)) - 1;
    lo = -(1 << (ww - 1));
    if (sat) begin
      if (s > hi)      s = hi;
      else if (s < lo) s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/weight_update_alu.sv
// STDP weight update datapath: widened signed add, then clamp (WMEM_SATURATE_EN) or wrap.
// The add and the reduction are split so the caller can register the wide sum in between.
module weight_update_alu
  import snn_wmem_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 9,
  parameter int DELTA_WIDTH  = 9
) (
  input  logic [WEIGHT_WIDTH-1:0] old_weight,
  input  logic [DELTA_WIDTH-1:0]  delta,
  output logic [WEIGHT_WIDTH:0]   sum,
  input  logic [WEIGHT_WIDTH:0]   sum_in,
  output logic [WEIGHT_WIDTH-1:0] new_weight
);

`ifdef WMEM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [WEIGHT_WIDTH:0] old_ext;
  logic [WEIGHT_WIDTH:0] delta_ext;

  assign old_ext   = {old_weight[WEIGHT_WIDTH-1], old_weight};
  assign delta_ext = {{(WEIGHT_WIDTH + 1 - DELTA_WIDTH){delta[DELTA_WIDTH-1]}}, delta};
  assign sum       = old_ext + delta_ext;

  // sum_in already holds old+delta, so the helper only has to reduce it.
  assign new_weight = WEIGHT_WIDTH'(sat_add(int'($signed(sum_in)), 0, WEIGHT_WIDTH, SAT));

endmodule

// File: rtl/weight_mem_arbiter.sv
// Arbitrates one 1R1W weight memory between inference reads, STDP read-modify-write
// and host writes. Build with WMEM_SATURATE_EN to clamp STDP updates instead of wrapping.
module weight_mem_arbiter
  import snn_wmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int WEIGHT_WIDTH = 9,
  parameter int DELTA_WIDTH  = 9,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inf_req,
  input  logic [ADDR_WIDTH-1:0]   inf_addr,
  output logic                    inf_gnt,
  output logic [WEIGHT_WIDTH-1:0] inf_rdata,
  output logic                    inf_rvalid,
  input  logic                    lrn_req,
  input  logic [ADDR_WIDTH-1:0]   lrn_addr,
  input  logic [DELTA_WIDTH-1:0]  lrn_delta,
  output logic                    lrn_gnt,
  output logic                    lrn_done,
  input  logic                    host_req,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [WEIGHT_WIDTH-1:0] host_data,
  output logic                    host_gnt,
  output logic                    mem_read_en,
  output logic [ADDR_WIDTH-1:0]   mem_read_addr,
  input  logic [WEIGHT_WIDTH-1:0] mem_read_data,
  input  logic                    mem_read_valid,
  output logic                    mem_write_en,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [WEIGHT_WIDTH-1:0] mem_write_data,
  output logic                    busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  rmw_state_e state, state_nxt;
  rd_owner_e  owner;

  logic [ADDR_WIDTH-1:0]   rmw_addr;
  logic [DELTA_WIDTH-1:0]  rmw_delta;
  logic [WEIGHT_WIDTH:0]   sum_q;
  logic [WEIGHT_WIDTH:0]   alu_sum;
  logic [WEIGHT_WIDTH-1:0] wb_weight;
  logic [SW-1:0]           starve_cnt;

  logic busy_i, starved, inf_cand, lrn_cand;
  logic inf_gnt_i, lrn_gnt_i, host_gnt_i;
  logic rd_en_i, wr_en_i, done_i;
  logic [ADDR_WIDTH-1:0]   rd_addr_i, wr_addr_i;
  logic [WEIGHT_WIDTH-1:0] wr_data_i;

  weight_update_alu #(
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .DELTA_WIDTH (DELTA_WIDTH)
  ) u_alu (
    .old_weight(mem_read_data),
    .delta     (rmw_delta),
    .sum       (alu_sum),
    .sum_in    (sum_q),
    .new_weight(wb_weight)
  );

  // Read-port arbitration; an inference read to the in-flight RMW address is held off
  // so it cannot observe the stale weight.
  assign busy_i     = (state != IDLE);
  assign starved    = (starve_cnt == LIMIT);
  assign inf_cand   = inf_req && !(busy_i && inf_addr == rmw_addr);
  assign lrn_cand   = lrn_req && (state == IDLE);
  assign lrn_gnt_i  = lrn_cand && (starved || !inf_cand);
  assign inf_gnt_i  = inf_cand && !lrn_gnt_i;
  assign rd_en_i    = inf_gnt_i || lrn_gnt_i;
  assign rd_addr_i  = lrn_gnt_i ? lrn_addr : inf_addr;
  assign host_gnt_i = host_req && (state != WB) && !(busy_i && host_addr == rmw_addr);

  always_comb begin
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    done_i    = 1'b0;
    if (state == WB) begin
      wr_en_i   = 1'b1;
      wr_addr_i = rmw_addr;
      wr_data_i = wb_weight;
      done_i    = 1'b1;
    end else if (host_gnt_i) begin
      wr_en_i   = 1'b1;
      wr_addr_i = host_addr;
      wr_data_i = host_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lrn_gnt_i) state_nxt = RD;
      RD:      state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_addr   <= '0;
      rmw_delta  <= '0;
      sum_q      <= '0;
      starve_cnt <= '0;
      owner      <= NONE;
    end else begin
      if (lrn_gnt_i) begin
        rmw_addr  <= lrn_addr;
        rmw_delta <= lrn_delta;
      end
      if (state == RD) sum_q <= alu_sum;
      if (lrn_gnt_i)                    starve_cnt <= '0;
      else if (lrn_req && !starved)     starve_cnt <= starve_cnt + 1'b1;
      owner <= inf_gnt_i ? INF : (lrn_gnt_i ? LRN : NONE);
    end
  end

  // Input-to-output paths are forced quiet while reset is held.
  assign inf_gnt        = !rst && inf_gnt_i;
  assign lrn_gnt        = !rst && lrn_gnt_i;
  assign host_gnt       = !rst && host_gnt_i;
  assign lrn_done       = !rst && done_i;
  assign busy           = !rst && busy_i;
  assign inf_rvalid     = !rst && mem_read_valid && (owner == INF);
  assign inf_rdata      = rst ? '0 : mem_read_data;
  assign mem_read_en    = !rst && rd_en_i;
  assign mem_read_addr  = rst ? '0 : rd_addr_i;
  assign mem_write_en   = !rst && wr_en_i;
  assign mem_write_addr = rst ? '0 : wr_addr_i;
  assign mem_write_data = rst ? '0 : wr_data_i;

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Bench for weight_mem_arbiter: RMW vector table, directed hazard/starvation/reset sequences,
// and a scoreboard of expected read data and RMW writes against a 1-cycle BRAM model.
module tb_weight_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inf_req = 1'b0, lrn_req = 1'b0, host_req = 1'b0;
  logic [11:0] inf_addr = '0, lrn_addr = '0, host_addr = '0;
  logic [8:0]  lrn_delta = '0, host_data = '0;
  logic       inf_gnt, inf_rvalid, lrn_gnt, lrn_done, host_gnt, busy;
  logic [8:0]  inf_rdata, mem_read_data, mem_write_data;
  logic       mem_read_en, mem_read_valid, mem_write_en;
  logic [11:0] mem_read_addr, mem_write_addr;

  always #5 clk = ~clk;

  weight_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inf_req(inf_req), .inf_addr(inf_addr), .inf_gnt(inf_gnt),
    .inf_rdata(inf_rdata), .inf_rvalid(inf_rvalid),
    .lrn_req(lrn_req), .lrn_addr(lrn_addr), .lrn_delta(lrn_delta),
    .lrn_gnt(lrn_gnt), .lrn_done(lrn_done),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_gnt(host_gnt),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .busy(busy)
  );

  // BRAM model: registered read (read-first), plus a bench-only preload port.
  logic [8:0]  mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [8:0]  pl_data = '0;

  always @(posedge clk) begin
    if (rst) mem_read_valid <= 1'b0;
    else     mem_read_valid <= mem_read_en;
    if (mem_read_en) mem_read_data <= mem[mem_read_addr];
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct { int addr; int data; } wr_t;
  int  exp_rd[$];
  wr_t exp_wr[$];

  always @(negedge clk) begin
    int  e;
    wr_t w;
    if (!rst) begin
      if (inf_rvalid) begin
        if (exp_rd.size() == 0) chk("inf_rvalid_unexpected", 1, 0);
        else begin
          e = exp_rd.pop_front();
          chk("inf_rdata", int'($signed(inf_rdata)), e);
        end
      end
      if (lrn_done) begin
        if (exp_wr.size() == 0) chk("lrn_done_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          chk("rmw_wen", int'(mem_write_en), 1);
          chk("rmw_waddr", int'(mem_write_addr), w.addr);
          chk("rmw_wdata", int'($signed(mem_write_data)), w.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      assert (!(inf_gnt && lrn_gnt)) else $error("FAIL assert_one_read_gnt");
      assert (!(mem_write_en && host_gnt && busy && host_addr == dut.rmw_addr))
        else $error("FAIL assert_host_rmw_collision");
      assert (!(host_gnt && lrn_done)) else $error("FAIL assert_host_during_wb");
      assert (dut.starve_cnt <= 15) else $error("FAIL assert_starve_bound");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic preload(input int a, input int v);
    pl_en = 1'b1; pl_addr = a[11:0]; pl_data = v[8:0];
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic inf_read(input int a, input int exp);
    inf_req = 1'b1; inf_addr = a[11:0];
    @(negedge clk);
    chk("inf_gnt", int'(inf_gnt), 1);
    chk("inf_rd_addr", int'(mem_read_addr), a);
    exp_rd.push_back(exp);
    @(posedge clk); #1 inf_req = 1'b0;
    @(negedge clk);
    chk("inf_rvalid_latency", int'(inf_rvalid), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_lrn_gnt(output int got);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (lrn_gnt) begin got = 1; break; end
    end
    chk("lrn_gnt_seen", got, 1);
  endtask

  task automatic rmw(input int a, input int d, input int exp);
    int got;
    exp_wr.push_back('{a, exp});
    lrn_req = 1'b1; lrn_addr = a[11:0]; lrn_delta = d[8:0];
    wait_lrn_gnt(got);
    @(posedge clk); #1 lrn_req = 1'b0;
    @(negedge clk);
    chk("busy_rd", int'(busy), 1);
    chk("no_write_rd", int'(mem_write_en), 0);
    @(negedge clk);
    chk("busy_wb", int'(busy), 1);
    chk("lrn_done_wb", int'(lrn_done), 1);
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_flags"}, int'({inf_gnt, lrn_gnt, host_gnt, lrn_done, busy,
                             inf_rvalid, mem_read_en, mem_write_en}), 0);
    chk({nm, "_addrs"}, int'({mem_read_addr, mem_write_addr}), 0);
    chk({nm, "_data"},  int'({inf_rdata, mem_write_data}), 0);
  endtask

  typedef struct { int addr; int init; int delta; int exp_wrap; int exp_sat; } vec_t;
  vec_t tbl[6];

  initial begin
    int e, got, gcyc, ninf;
    tbl[0] = '{32'h020,  100,    5,  105,  105};
    tbl[1] = '{32'h021,  250,   20, -242,  255};
    tbl[2] = '{32'h022, -250,  -20,  242, -256};
    tbl[3] = '{32'h023,    0,   -1,   -1,   -1};
    tbl[4] = '{32'h024,  255,  255,   -2,  255};
    tbl[5] = '{32'h025, -256, -256,    0, -256};

    // Reset: requests asserted, every output must stay low.
    inf_req = 1'b1; inf_addr = 12'h123; lrn_req = 1'b1; lrn_addr = 12'h124;
    host_req = 1'b1; host_addr = 12'h321; host_data = 9'h1AA;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0; inf_req = 1'b0; lrn_req = 1'b0; host_req = 1'b0;

    // Plain inference read.
    preload(32'h010, 32'h055);
    inf_read(32'h010, 32'h055);

    // RMW vectors, each followed by a read-back of the written weight.
    for (int i = 0; i < 6; i++) begin
      preload(tbl[i].addr, tbl[i].init);
`ifdef WMEM_SATURATE_EN
      e = tbl[i].exp_sat;
`else
      e = tbl[i].exp_wrap;
`endif
      rmw(tbl[i].addr, tbl[i].delta, e);
      inf_read(tbl[i].addr, e);
    end

    // Starvation: inference held every cycle, learning wins on pending cycle 16.
    preload(32'h100, 170);
    preload(32'h040, 10);
    exp_wr.push_back('{32'h040, 13});
    inf_req = 1'b1; inf_addr = 12'h100;
    lrn_req = 1'b1; lrn_addr = 12'h040; lrn_delta = 9'd3;
    gcyc = 0; ninf = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (inf_gnt) begin exp_rd.push_back(170); ninf++; end
      if (lrn_gnt) begin
        gcyc = c;
        chk("inf_stall_on_starve", int'(inf_gnt), 0);
        break;
      end
      @(posedge clk); #1;
    end
    chk("starve_gnt_cycle", gcyc, 16);
    chk("inf_gnts_before_starve", ninf, 15);
    @(posedge clk); #1 lrn_req = 1'b0;
    @(negedge clk);
    chk("inf_resume", int'(inf_gnt), 1);
    if (inf_gnt) exp_rd.push_back(170);
    @(posedge clk); #1 inf_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Address hazard: inference and host to the RMW address wait for IDLE.
    preload(32'h030, 40);
    exp_wr.push_back('{32'h030, 33});
    lrn_req = 1'b1; lrn_addr = 12'h030; lrn_delta = 9'(-7);
    wait_lrn_gnt(got);
    @(posedge clk); #1;
    lrn_req = 1'b0;
    inf_req = 1'b1; inf_addr = 12'h030;
    host_req = 1'b1; host_addr = 12'h030; host_data = 9'd77;
    @(negedge clk);
    chk("hz_inf_gnt_rd", int'(inf_gnt), 0);
    chk("hz_host_gnt_rd", int'(host_gnt), 0);
    @(negedge clk);
    chk("hz_inf_gnt_wb", int'(inf_gnt), 0);
    chk("hz_host_gnt_wb", int'(host_gnt), 0);
    @(negedge clk);
    chk("hz_inf_gnt_idle", int'(inf_gnt), 1);
    chk("hz_host_gnt_idle", int'(host_gnt), 1);
    exp_rd.push_back(33);  // read-first: same-cycle host write not visible
    @(posedge clk); #1 inf_req = 1'b0; host_req = 1'b0;
    inf_read(32'h030, 77);

    // Reset in RD aborts the RMW: no write, no done, outputs quiet.
    preload(32'h050, 60);
    lrn_req = 1'b1; lrn_addr = 12'h050; lrn_delta = 9'd1;
    wait_lrn_gnt(got);
    @(posedge clk); #1;
    lrn_req = 1'b0;
    rst = 1'b1;
    inf_req = 1'b1; inf_addr = 12'h051; host_req = 1'b1; host_addr = 12'h052;
    @(negedge clk);
    chk_quiet("rst_mid_rmw");
    @(negedge clk);
    chk("rst_no_write", int'({mem_write_en, lrn_done}), 0);
    @(posedge clk); #1;
    rst = 1'b0; inf_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", int'({busy, mem_write_en}), 0);
    @(posedge clk); #1;
    inf_read(32'h050, 60);
    rmw(32'h050, 1, 61);
    inf_read(32'h050, 61);

    repeat (3) @(posedge clk);
    chk("rd_scoreboard_empty", exp_rd.size(), 0);
    chk("wr_scoreboard_empty", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
